// File: rtl/inst_mem_axi_slave_pkg.sv
// Shared types and constants for the instruction-memory AXI read responder.
// Holds FSM encoding, line-fill burst length and default parameter values.
package inst_mem_axi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_BURST
  } state_t;

  localparam logic [3:0] LINE_BEATS_M1 = 4'd7;

  localparam int DEF_MEM_AW = 12;
  localparam int DEF_FIRST_BEAT_DELAY = 2;

endpackage

// File: rtl/inst_mem_array.sv
// Word-wide backing store: one preload write port, one async read port.
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_addr -> rd_data (read).
module inst_mem_array #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_mem_axi_slave.sv
// AXI-style INCR read responder over a preloadable instruction memory.
// Ports: clk, rst, AR channel (s_ar*), R channel (s_r*), preload (ld_*).
module inst_mem_axi_slave
  import inst_mem_axi_slave_pkg::*;
#(
  parameter int MEM_AW           = DEF_MEM_AW,
  parameter int FIRST_BEAT_DELAY = DEF_FIRST_BEAT_DELAY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_araddr,
  input  logic [3:0]        s_arlen,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic              s_rvalid,
  output logic              s_rlast,
  input  logic              s_rready,
  input  logic              ld_en,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  state_t state, state_nx;

  logic [MEM_AW-1:0] base;
  logic [MEM_AW-1:0] rd_addr;
  logic [3:0]        len;
  logic [3:0]        beat;
  logic [3:0]        cnt;
  logic [3:0]        fetch_beat;
  logic [31:0]       rd_data;
  logic              ar_hs;
  logic              r_hs;
  logic              last_hs;
  logic              unused_addr;

  assign unused_addr = ^{s_araddr[31:MEM_AW+2], s_araddr[1:0]};

  assign s_arready = (state == ST_IDLE);
  assign ar_hs     = s_arvalid & s_arready;
  assign r_hs      = s_rvalid & s_rready;
  assign last_hs   = r_hs & (beat == len);

  // First fetch in BURST reads beat 0; afterwards we prefetch the next beat
  // so the register is refilled on the same edge the current beat retires.
  assign fetch_beat = s_rvalid ? beat + 4'd1 : beat;
  assign rd_addr    = base + MEM_AW'(fetch_beat);

  inst_mem_array #(.AW(MEM_AW)) u_mem (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (ar_hs)
          state_nx = (FIRST_BEAT_DELAY == 0) ? ST_BURST : ST_DELAY;
      end
      ST_DELAY: begin
        if (cnt <= 4'd1) state_nx = ST_BURST;
      end
      ST_BURST: begin
        if (last_hs) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= '0;
      len      <= '0;
      beat     <= '0;
      cnt      <= '0;
      s_rdata  <= '0;
      s_rvalid <= 1'b0;
      s_rlast  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            base <= s_araddr[MEM_AW+1:2];
            len  <= s_arlen;
            beat <= '0;
            cnt  <= 4'(FIRST_BEAT_DELAY);
          end
        end
        ST_DELAY: begin
          cnt <= cnt - 4'd1;
        end
        ST_BURST: begin
          if (!s_rvalid) begin
            s_rdata  <= rd_data;
            s_rvalid <= 1'b1;
            s_rlast  <= (len == 4'd0);
          end else if (r_hs) begin
            if (beat == len) begin
              s_rvalid <= 1'b0;
              s_rlast  <= 1'b0;
            end else begin
              beat    <= beat + 4'd1;
              s_rdata <= rd_data;
              s_rlast <= (beat + 4'd1 == len);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_axi_slave.sv
// Directed bench: default-delay responder plus a zero-delay build.
// Both share clk, rst and the preload bus.
module tb_inst_mem_axi_slave;
  import inst_mem_axi_slave_pkg::*;

  logic        clk;
  logic        rst;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rlast, rready;

  logic [31:0] z_araddr;
  logic [3:0]  z_arlen;
  logic        z_arvalid, z_arready;
  logic [31:0] z_rdata;
  logic        z_rvalid, z_rlast, z_rready;

  int n_cmp;
  int n_bad;
  logic [31:0] ev [8];

  inst_mem_axi_slave dut (
    .clk       (clk),
    .rst       (rst),
    .s_araddr  (araddr),
    .s_arlen   (arlen),
    .s_arvalid (arvalid),
    .s_arready (arready),
    .s_rdata   (rdata),
    .s_rvalid  (rvalid),
    .s_rlast   (rlast),
    .s_rready  (rready),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  inst_mem_axi_slave #(.FIRST_BEAT_DELAY(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .s_araddr  (z_araddr),
    .s_arlen   (z_arlen),
    .s_arvalid (z_arvalid),
    .s_arready (z_arready),
    .s_rdata   (z_rdata),
    .s_rvalid  (z_rvalid),
    .s_rlast   (z_rlast),
    .s_rready  (z_rready),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [11:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic ar_issue(input logic [31:0] a, input logic [3:0] l);
    chk("arready_pre", {31'd0, arready}, 32'd1);
    araddr = a;
    arlen = l;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    while (rvalid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_burst(input string tag, input logic [31:0] a,
                           input logic [3:0] l);
    int n;
    ar_issue(a, l);
    wait_rv(n);
    chk({tag, "_latency"}, n, 32'd3);
    for (int k = 0; k <= int'(l); k++) begin
      chk({tag, "_data"}, rdata, ev[k]);
      chk({tag, "_rlast"}, {31'd0, rlast}, {31'd0, k == int'(l)});
      chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
      tick();
    end
    chk({tag, "_end_rvalid"}, {31'd0, rvalid}, 32'd0);
    chk({tag, "_end_rlast"}, {31'd0, rlast}, 32'd0);
    chk({tag, "_end_arready"}, {31'd0, arready}, 32'd1);
  endtask

  initial begin
    int n;
    int idx;
    int c;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    araddr = '0;
    arlen = '0;
    arvalid = 1'b0;
    rready = 1'b1;
    z_araddr = '0;
    z_arlen = '0;
    z_arvalid = 1'b0;
    z_rready = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 8; i++) ld(12'h100 + 12'(i), 32'hA0 + 32'(i));
    ld(12'hFFE, 32'hBFE);
    ld(12'hFFF, 32'hBFF);
    for (int i = 0; i < 6; i++) ld(12'(i), 32'hC0 + 32'(i));

    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rlast", {31'd0, rlast}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_z_arready", {31'd0, z_arready}, 32'd1);
    chk("rst_z_rvalid", {31'd0, z_rvalid}, 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) ev[k] = 32'hA0 + 32'(k);
    run_burst("line", 32'h0000_0400, LINE_BEATS_M1);

    ev[0] = 32'hA1;
    run_burst("single", 32'h0000_0404, 4'd0);

    for (int k = 0; k < 8; k++) ev[k] = 32'hA0 + 32'(k);
    rready = 1'b0;
    ar_issue(32'h0000_0400, 4'd7);
    wait_rv(n);
    chk("stall_latency", n, 32'd3);
    idx = 0;
    c = 0;
    while (idx < 8 && c < 100) begin
      rready = (c % 3 == 0);
      chk("stall_rvalid", {31'd0, rvalid}, 32'd1);
      chk("stall_data", rdata, ev[idx]);
      chk("stall_rlast", {31'd0, rlast}, {31'd0, idx == 7});
      if (rready) idx++;
      tick();
      c++;
    end
    chk("stall_count", idx, 32'd8);
    chk("stall_end_rvalid", {31'd0, rvalid}, 32'd0);
    rready = 1'b1;

    ev[0] = 32'hBFE;
    ev[1] = 32'hBFF;
    for (int k = 2; k < 8; k++) ev[k] = 32'hC0 + 32'(k - 2);
    run_burst("wrap", 32'h0000_3FF8, 4'd7);

    for (int k = 0; k < 8; k++) ev[k] = 32'hA0 + 32'(k);
    ar_issue(32'h0000_0400, 4'd7);
    wait_rv(n);
    chk("abort_latency", n, 32'd3);
    for (int k = 0; k < 3; k++) tick();
    chk("abort_beat3", rdata, 32'hA3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rvalid", {31'd0, rvalid}, 32'd0);
    chk("abort_rlast", {31'd0, rlast}, 32'd0);
    chk("abort_arready", {31'd0, arready}, 32'd1);
    chk("abort_rdata", rdata, 32'd0);
    run_burst("after_abort", 32'h0000_0400, 4'd7);

    z_araddr = 32'h0000_0400;
    z_arlen = 4'd1;
    z_arvalid = 1'b1;
    tick();
    z_araddr = 32'h0000_0404;
    z_arlen = 4'd0;
    chk("z_arready_busy0", {31'd0, z_arready}, 32'd0);
    chk("z_rvalid_e0", {31'd0, z_rvalid}, 32'd0);
    tick();
    chk("z_rvalid_e1", {31'd0, z_rvalid}, 32'd1);
    chk("z_beat0", z_rdata, 32'hA0);
    chk("z_rlast0", {31'd0, z_rlast}, 32'd0);
    tick();
    chk("z_beat1", z_rdata, 32'hA1);
    chk("z_rlast1", {31'd0, z_rlast}, 32'd1);
    chk("z_arready_busy1", {31'd0, z_arready}, 32'd0);
    tick();
    chk("z_done_rvalid", {31'd0, z_rvalid}, 32'd0);
    chk("z_done_arready", {31'd0, z_arready}, 32'd1);
    tick();
    z_arvalid = 1'b0;
    chk("z_second_taken", {31'd0, z_arready}, 32'd0);
    chk("z_second_rv0", {31'd0, z_rvalid}, 32'd0);
    tick();
    chk("z_second_rvalid", {31'd0, z_rvalid}, 32'd1);
    chk("z_second_data", z_rdata, 32'hA1);
    chk("z_second_rlast", {31'd0, z_rlast}, 32'd1);
    tick();
    chk("z_second_end", {31'd0, z_rvalid}, 32'd0);

    rready = 1'b0;
    ar_issue(32'h0000_0400, 4'd1);
    wait_rv(n);
    chk("ld_latency", n, 32'd3);
    chk("ld_beat0_pre", rdata, 32'hA0);
    ld(12'h100, 32'h55);
    chk("ld_beat0_held", rdata, 32'hA0);
    ld(12'h101, 32'h66);
    chk("ld_beat0_held2", rdata, 32'hA0);
    rready = 1'b1;
    tick();
    chk("ld_beat1_new", rdata, 32'h66);
    chk("ld_beat1_rlast", {31'd0, rlast}, 32'd1);
    tick();
    chk("ld_end", {31'd0, rvalid}, 32'd0);
    ev[0] = 32'h55;
    run_burst("ld_reread", 32'h0000_0400, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
